// File: rtl/fetch_unit_if.sv
// Fetch unit bus: imem request/response channel, ID-stage handshake and redirect.
// Optional FETCH_PERF_EN adds the perf_fetched / perf_discarded counters.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_discarded;
`endif

  // Fetch unit side
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output id_valid, id_pc, id_instr,
    input  id_ready,
    input  redirect_valid, redirect_pc
`ifdef FETCH_PERF_EN
    , output perf_fetched, perf_discarded
`endif
  );

  // Instruction memory / ID stage / redirect source side
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  id_valid, id_pc, id_instr,
    output id_ready,
    output redirect_valid, redirect_pc
`ifdef FETCH_PERF_EN
    , input perf_fetched, perf_discarded
`endif
  );
endinterface

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, issues in-order word fetches under a credit limit,
// buffers returned words with their PCs in a small FIFO and presents the head
// to ID. Redirect flushes the FIFO and discards every response still in flight.
// Optional macro FETCH_PERF_EN adds fetched/discarded performance counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  logic [31:0]   pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] outstanding_next;
  logic [OW-1:0] discard;

  logic credit_ok;
  logic req_fire;
  logic rsp_accept;
  logic rsp_drop;
  logic push;
  logic pop;
  logic id_valid;

  // Buffer slots plus in-flight requests may never exceed the FIFO size,
  // which is what guarantees a returning word always has a slot.
  assign credit_ok = ((32'(fifo_count) + 32'(outstanding)) < 32'(FIFO_DEPTH)) &&
                     (32'(outstanding) < 32'(MAX_OUTSTANDING));
  assign bus.imem_req_valid = rst_n && credit_ok;
  assign bus.imem_req_addr  = pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  // Responses with no credit behind them (e.g. after a reset) are ignored.
  assign rsp_accept = bus.imem_rsp_valid && (outstanding != '0);
  assign rsp_drop   = rsp_accept && ((discard != '0) || bus.redirect_valid);
  assign push       = rsp_accept && (discard == '0) && !bus.redirect_valid;

  assign outstanding_next = outstanding + OW'(req_fire) - OW'(rsp_accept);

  // ID sees only registered FIFO contents; the zero gating keeps idle outputs clean.
  assign id_valid     = (fifo_count != '0);
  assign pop          = id_valid && bus.id_ready && !bus.redirect_valid;
  assign bus.id_valid = id_valid;
  assign bus.id_pc    = id_valid ? fifo_pc[rd_ptr]    : 32'h0;
  assign bus.id_instr = id_valid ? fifo_instr[rd_ptr] : 32'h0;

  // Control state: PC, response PC, FIFO pointers and the credit/discard counters.
  // NOTE: every register in a clocked block uses <= so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (bus.redirect_valid) begin
        pc         <= {bus.redirect_pc[31:2], 2'b00};
        rsp_pc     <= {bus.redirect_pc[31:2], 2'b00};
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
        discard    <= outstanding_next;
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (push) begin
          rsp_pc <= rsp_pc + 32'd4;
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
        if (rsp_drop) discard <= discard - OW'(1);
      end
    end
  end

  // FIFO storage: written on push, read through rd_ptr.
  // NOTE: the data array is not reset; fifo_count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= rsp_pc;
      fifo_instr[wr_ptr] <= bus.imem_rsp_data;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_discarded;

  // Count delivered instructions and every word thrown away (dropped or flushed).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched   <= '0;
      perf_discarded <= '0;
    end else begin
      if (pop) perf_fetched <= perf_fetched + 32'd1;
      perf_discarded <= perf_discarded + 32'(rsp_drop) +
                        (bus.redirect_valid ? 32'(fifo_count) : 32'd0);
    end
  end

  assign bus.perf_fetched   = perf_fetched;
  assign bus.perf_discarded = perf_discarded;
`endif

  // Credit accounting must make FIFO overflow and discard overrun impossible.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (32'(fifo_count) == 32'(FIFO_DEPTH))));
  assert property (@(posedge clk) disable iff (!rst_n) discard <= outstanding);

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: a hand-computed vector table for the cycle-exact
// behaviour, then model-driven sequences (latency, stall, redirect, random
// ready, mid-stream reset) checked against an in-order PC scoreboard.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int FIFO_DEPTH      = 4;
  localparam int MAX_OUTSTANDING = 2;

  logic clk = 1'b0;
  logic rst_n;
  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        id_ready;
    logic        redir;
    logic [31:0] redir_pc;
    logic        exp_req_valid;
    logic [31:0] exp_addr;
    logic        exp_id_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  // ---------------- imem model + scoreboard ----------------
  typedef struct {
    int          due;
    logic [31:0] addr;
  } inflight_t;

  inflight_t   mq[$];
  int          cyc = 0;
  int          lat = 1;
  int          ready_mode = 0;   // 0: always ready, 1: random, 2: never
  logic        id_rdy_drv = 1'b1;
  logic        redir_drv = 1'b0;
  logic [31:0] redir_target = '0;
  logic [31:0] exp_pc;
  logic [31:0] exp_req;
  int          fires = 0;
  int          pops = 0;

  task automatic cycle();
    logic        fire;
    logic        pop;
    logic [31:0] faddr;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
    end
    case (ready_mode)
      0:       bus.imem_req_ready = 1'b1;
      1:       bus.imem_req_ready = 1'($urandom_range(0, 1));
      default: bus.imem_req_ready = 1'b0;
    endcase
    bus.id_ready       = id_rdy_drv;
    bus.redirect_valid = redir_drv;
    bus.redirect_pc    = redir_target;
    #1;
    fire  = bus.imem_req_valid && bus.imem_req_ready;
    faddr = bus.imem_req_addr;
    pop   = bus.id_valid && bus.id_ready && !bus.redirect_valid && rst_n;
    if (fire) begin
      check("req_addr", faddr, exp_req);
      exp_req = exp_req + 32'd4;
      fires++;
    end
    if (pop) begin
      check("id_pc", bus.id_pc, exp_pc);
      check("id_instr", bus.id_instr, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (redir_drv) begin
      exp_req = {redir_target[31:2], 2'b00};
      exp_pc  = {redir_target[31:2], 2'b00};
    end
    @(posedge clk);
    #1;
    if (fire) mq.push_back('{due: cyc + lat, addr: faddr});
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_inflight(input int n, input string name);
    for (int i = 0; i < 30; i++) begin
      if (mq.size() == n) break;
      cycle();
    end
    check(name, 128'(mq.size()), 128'(n));
  endtask

  initial begin
    int p0;
    // inputs: req_ready, rsp_valid, rsp_data, id_ready, redir, redir_pc
    // expect: req_valid, req_addr, id_valid, id_pc, id_instr (after the edge)
    vecs[0]  = '{1, 0, 32'h0,         0, 0, 32'h0,   1, 32'h4,   0, 32'h0,   32'h0};
    vecs[1]  = '{1, 0, 32'h0,         0, 0, 32'h0,   0, 32'h8,   0, 32'h0,   32'h0};
    vecs[2]  = '{1, 1, 32'hA000_0000, 0, 0, 32'h0,   1, 32'h8,   1, 32'h0,   32'hA000_0000};
    vecs[3]  = '{1, 1, 32'hA000_0001, 0, 0, 32'h0,   1, 32'hC,   1, 32'h0,   32'hA000_0000};
    vecs[4]  = '{1, 1, 32'hA000_0002, 0, 0, 32'h0,   0, 32'h10,  1, 32'h0,   32'hA000_0000};
    vecs[5]  = '{1, 1, 32'hA000_0003, 0, 0, 32'h0,   0, 32'h10,  1, 32'h0,   32'hA000_0000};
    vecs[6]  = '{1, 0, 32'h0,         1, 0, 32'h0,   1, 32'h10,  1, 32'h4,   32'hA000_0001};
    vecs[7]  = '{0, 0, 32'h0,         1, 0, 32'h0,   1, 32'h10,  1, 32'h8,   32'hA000_0002};
    vecs[8]  = '{1, 0, 32'h0,         1, 1, 32'h103, 1, 32'h100, 0, 32'h0,   32'h0};
    vecs[9]  = '{1, 1, 32'hBAD0_0000, 1, 0, 32'h0,   1, 32'h104, 0, 32'h0,   32'h0};
    vecs[10] = '{0, 1, 32'hC000_0000, 1, 0, 32'h0,   1, 32'h104, 1, 32'h100, 32'hC000_0000};
    vecs[11] = '{0, 0, 32'h0,         1, 0, 32'h0,   1, 32'h104, 0, 32'h0,   32'h0};
    vecs[12] = '{1, 0, 32'h0,         1, 0, 32'h0,   1, 32'h108, 0, 32'h0,   32'h0};
    vecs[13] = '{1, 1, 32'hBAD0_0001, 1, 1, 32'h200, 1, 32'h200, 0, 32'h0,   32'h0};
    vecs[14] = '{1, 1, 32'hBAD0_0002, 1, 0, 32'h0,   1, 32'h204, 0, 32'h0,   32'h0};
    vecs[15] = '{0, 1, 32'hC000_0001, 1, 0, 32'h0,   1, 32'h204, 1, 32'h200, 32'hC000_0001};
    vecs[16] = '{0, 0, 32'h0,         0, 0, 32'h0,   1, 32'h204, 1, 32'h200, 32'hC000_0001};
    vecs[17] = '{0, 0, 32'h0,         1, 0, 32'h0,   1, 32'h204, 0, 32'h0,   32'h0};

    // Reset state
    rst_n = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", bus.imem_req_valid, 0);
    check("rst_id_valid", bus.id_valid, 0);
    check("rst_id_pc", bus.id_pc, 0);
    check("rst_id_instr", bus.id_instr, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_req", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, RESET_PC});

    // Table-driven cycle-exact vectors
    for (int i = 0; i < NV; i++) begin
      bus.imem_req_ready = vecs[i].req_ready;
      bus.imem_rsp_valid = vecs[i].rsp_valid;
      bus.imem_rsp_data  = vecs[i].rsp_data;
      bus.id_ready       = vecs[i].id_ready;
      bus.redirect_valid = vecs[i].redir;
      bus.redirect_pc    = vecs[i].redir_pc;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i),
            {bus.imem_req_valid, bus.imem_req_addr, bus.id_valid, bus.id_pc, bus.id_instr},
            {vecs[i].exp_req_valid, vecs[i].exp_addr, vecs[i].exp_id_valid,
             vecs[i].exp_pc, vecs[i].exp_instr});
    end

    // Fresh start for the model-driven sequences
    rst_n = 1'b0;
    ready_mode = 2;
    cycle();
    rst_n = 1'b1;
    exp_pc = RESET_PC;
    exp_req = RESET_PC;
    fires = 0;
    pops = 0;
    lat = 1;
    ready_mode = 0;
    id_rdy_drv = 1'b1;

    // Streaming: one instruction per cycle once filled
    run(6);
    p0 = pops;
    run(10);
    check("stream_rate", 128'(pops - p0), 128'd10);

    // Stall: FIFO fills to depth and requests stop
    id_rdy_drv = 1'b0;
    run(10);
    check("stall_req_valid", bus.imem_req_valid, 0);
    check("stall_fifo_full", 128'(fires - pops), 128'(FIFO_DEPTH));
    check("stall_none_inflight", 128'(mq.size()), 128'd0);
    id_rdy_drv = 1'b1;
    run(20);

    // Redirect with two requests in flight (3-cycle latency)
    lat = 3;
    wait_inflight(2, "redir_inflight");
    redir_drv = 1'b1;
    redir_target = 32'h0000_0103;
    cycle();
    redir_drv = 1'b0;
    check("redir_id_flushed", bus.id_valid, 0);
    p0 = pops;
    run(20);
    check("redir_delivered", 128'(pops > p0), 128'd1);

    // Random request back-pressure
    ready_mode = 1;
    p0 = pops;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (mq.size() > MAX_OUTSTANDING) check("max_outstanding", 128'(mq.size()), 128'(MAX_OUTSTANDING));
    end
    check("random_progress", 128'(pops - p0 > 20), 128'd1);

    // Reset mid-stream with two requests in flight
    ready_mode = 0;
    wait_inflight(2, "rst_inflight");
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    exp_pc = RESET_PC;
    exp_req = RESET_PC;
    ready_mode = 2;
    check("midrst_id_valid", bus.id_valid, 0);
    for (int i = 0; i < 10 && mq.size() > 0; i++) begin
      cycle();
      check("midrst_late_ignored", bus.id_valid, 0);
    end
    check("midrst_drained", 128'(mq.size()), 128'd0);
    ready_mode = 0;
    p0 = pops;
    run(15);
    check("midrst_restart", 128'(pops > p0), 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
